pbit_input_accumulator: RTL
===========================

// Module: pbit_input_accumulator
// PURPOSE
//  Computes the local field z_i = h_i + sum_j J_ij*m_j for one p-bit, in signed Q8.24
//  (INT_SIZE.FLOAT_SIZE), and presents it to the p-bit's z input.
//  Holds the neighbour weights J_ij and the bias h_i in local registers.
//  Works through the neighbours one per clock. Neighbour states are bipolar: bit 1 = +1, bit 0 = -1.
//  Sits directly upstream of the p-bit stage. One instance is used per p-bit in the network.
// PARAMETERS
//  FLOAT_SIZE  24  fractional bits of the fixed-point format
//  INT_SIZE    8   integer bits including sign; word width W = INT_SIZE+FLOAT_SIZE = 32
//  N_NEIGH     8   number of neighbour p-bits (>=2); IDX_W = $clog2(N_NEIGH) (localparam)
// PORTS
//  CLK        in   1        system clock, rising edge
//  RST        in   1        asynchronous reset, active-high
//  w_we       in   1        weight write strobe
//  w_addr     in   IDX_W    neighbour index for the weight write
//  w_data     in   W        signed Q8.24 weight J_ij
//  bias_we    in   1        bias write strobe
//  bias_data  in   W        signed Q8.24 bias h_i
//  m_in       in   N_NEIGH  neighbour p-bit states; bit j = m_j
//  start      in   1        request a new field computation
//  busy       out  1        high while a computation is in progress
//  z          out  W        signed Q8.24 saturated local field (feeds p-bit z)
//  z_valid    out  1        one-cycle pulse when z is updated
// BEHAVIOUR
//  Reset (RST=1, asynchronous):
//   - state=IDLE; busy=0; z=0; z_valid=0; idx=0.
//   - All N_NEIGH weights and the bias are cleared to 0.
//  FSM: IDLE -> ACCUM -> DONE -> IDLE.
//   - IDLE, start=1:
//     - m_in is latched into m_q.
//     - acc <= sign-extended bias.
//     - idx <= 0; go to ACCUM; busy=1 from the next cycle.
//   - ACCUM, each cycle:
//     - acc <= acc + (m_q[idx] ? w[idx] : -w[idx]); idx <= idx+1.
//     - After the term for idx=N_NEIGH-1 is added, go to DONE.
//   - DONE, one cycle:
//     - z <= sat(acc); z_valid=1; busy=0.
//     - Return to IDLE.
//  Latency: start sampled at edge t gives z_valid high during the cycle after edge t+N_NEIGH+1.
//   - Back-to-back runs: start may be reasserted in the cycle z_valid is high (FSM is in IDLE).
//  Arithmetic:
//   - acc is signed, W+IDX_W+2 bits wide.
//   - Negation is done in the acc width, so -(-2^31) is exact.
//   - No overflow is possible inside acc.
//  Saturation when loading z:
//   - acc > 0x7FFFFFFF gives z=0x7FFFFFFF.
//   - acc < -0x80000000 gives z=0x80000000.
//   - Otherwise z = acc[W-1:0].
//  z holds its value between runs. z_valid is 0 in every cycle other than DONE.
//  While busy=1:
//   - start is ignored (not queued).
//   - w_we and bias_we are ignored (the write is dropped).
//   - m_in changes have no effect (m_q is used).
//  While idle, w_we and bias_we may be asserted in the same cycle. Both writes take effect.
//  w_addr >= N_NEIGH (non-power-of-2 N_NEIGH): the write is dropped.
//  RST during ACCUM/DONE: the run aborts immediately; no z_valid; all outputs go to reset values.
// TESTING
//  1. Reset: assert RST mid-cycle -> busy=0, z=0, z_valid=0 immediately; later run with no writes gives z=0.
//  2. All w=0x01000000, bias=0, m_in=8'hFF, start -> z_valid exactly 9 cycles after start edge, z=0x08000000.
//  3. Same weights, m_in=8'h0F -> z=0x00000000; then bias=0x00800000, m_in=8'h0F -> z=0x00800000.
//  4. All w=0x7F000000, m_in=8'hFF -> z=0x7FFFFFFF; m_in=8'h00 -> z=0x80000000 (saturation both signs).
//  5. During busy:
//     - pulse start, write w[0]=0xFF000000, change m_in.
//     - Expect: one z_valid only, result equals case 2, w[0] unchanged on the next run.
//  6. RST pulsed during ACCUM (cycle 4) -> no z_valid, weights cleared.
//     - A following start with m_in=8'hFF gives z=0 after 9 cycles.

Source files
------------

// File: rtl/pbit_input_accumulator.sv
// pbit_input_accumulator: local-field accumulator for one p-bit.
// Computes z = sat(h + sum_j J_j * m_j) in signed Q(INT_SIZE).(FLOAT_SIZE)
// fixed point. It walks the neighbours one per clock, and each neighbour
// state is bipolar (1 -> +J, 0 -> -J).
//
// Handshake: a computation is requested by asserting start while busy=0.
// The request is accepted on that clock edge and needs no acknowledge.
// busy goes high from the next cycle and stays high until the result is
// loaded. z_valid is a one-cycle pulse that marks the update of z. busy is
// already low in that cycle, so start may be reasserted there for
// back-to-back runs. A start that arrives while busy=1 is dropped. It is
// not queued.
module pbit_input_accumulator #(
    parameter int FLOAT_SIZE = 24,
    parameter int INT_SIZE   = 8,
    parameter int N_NEIGH    = 8,
    localparam int W         = INT_SIZE + FLOAT_SIZE,
    localparam int IDX_W     = $clog2(N_NEIGH)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               w_we,
    input  logic [IDX_W-1:0]   w_addr,
    input  logic [W-1:0]       w_data,
    input  logic               bias_we,
    input  logic [W-1:0]       bias_data,
    input  logic [N_NEIGH-1:0] m_in,
    input  logic               start,
    output logic               busy,
    output logic [W-1:0]       z,
    output logic               z_valid,
    output logic [1:0]         dbg_state
);

    // Accumulator is wide enough that N_NEIGH terms of magnitude up to 2^(W-1)
    // plus the bias can never overflow it.
    localparam int ACC_W = W + IDX_W + 2;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(N_NEIGH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                   state;
    logic [W-1:0]             w_mem [N_NEIGH];
    logic [W-1:0]             bias_q;
    logic [N_NEIGH-1:0]       m_q;
    logic [IDX_W-1:0]         idx;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  w_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  term;
    logic [W-1:0]             acc_sat;
    logic                     w_addr_ok;

    assign dbg_state = state;

    // Out-of-range addresses only exist when N_NEIGH is not a power of two.
    assign w_addr_ok = ({1'b0, w_addr} < (IDX_W+1)'(N_NEIGH));

    // Signed term for the current neighbour: the negation happens in the full
    // accumulator width, so negating the most negative weight is exact.
    always_comb begin
        w_ext    = {{(ACC_W-W){w_mem[idx][W-1]}}, w_mem[idx]};
        bias_ext = {{(ACC_W-W){bias_q[W-1]}}, bias_q};
        term     = m_q[idx] ? w_ext : -w_ext;
    end

    // Saturate the wide accumulator back into the W-bit output format.
    always_comb begin
        acc_sat = acc[W-1:0];
        if (acc > SAT_MAX) begin
            acc_sat = SAT_MAX[W-1:0];
        end else if (acc < SAT_MIN) begin
            acc_sat = SAT_MIN[W-1:0];
        end
    end

    // Weight and bias registers; writes are accepted only while idle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int j = 0; j < N_NEIGH; j++) begin
                w_mem[j] <= '0;
            end
            bias_q <= '0;
        end else if (state == IDLE) begin
            if (w_we && w_addr_ok) begin
                w_mem[w_addr] <= w_data;
            end
            if (bias_we) begin
                bias_q <= bias_data;
            end
        end
    end

    // Control FSM: IDLE -> ACCUM (N_NEIGH cycles) -> DONE -> IDLE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            busy    <= 1'b0;
            z       <= '0;
            z_valid <= 1'b0;
            idx     <= '0;
            acc     <= '0;
            m_q     <= '0;
        end else begin
            z_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m_q   <= m_in;
                        acc   <= bias_ext;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc + term;
                    if (idx == IDX_LAST) begin
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    z       <= acc_sat;
                    z_valid <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
